// File: rtl/reg_alu_n.sv
// reg_alu_n: width-parametrised registered ALU with a stored flag register
// {V,N,Z,C}, carry chaining and an iterative shift-and-add multiplier.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready operation handshake (accept when both high)
//   alu_sel[3:0]        opcode
//   a, b [WIDTH]        operands
//   cin, use_cf         instruction carry-in; use_cf selects stored C instead
//   alu_out [WIDTH]     registered result (low half of product for MUL)
//   alu_out_hi [WIDTH]  MUL high half, 0 after other result-writing ops
//   cout                stored C flag
//   flags[3:0]          stored {V,N,Z,C}
//   out_valid           one-cycle strobe per completed operation
module reg_alu_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             use_cf,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             cout,
  output logic [3:0]       flags,
  output logic             out_valid
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_TRA  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_DEC  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROLC = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_CMP  = 4'd13;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [3:0]           flags_q, flags_d;
  logic                 vld_p0_q, vld_p0_d;

  logic                 accept;
  logic                 c_eff;
  logic [WIDTH-1:0]     b_eff;
  logic                 c_add;
  logic [WIDTH:0]       sum_w;
  logic                 add_v;
  logic [2*WIDTH-1:0]   prod_nxt;

  // Packs {V,N,Z,C} for a WIDTH-bit result.
  function automatic logic [3:0] pack_flags(input logic v, input logic [WIDTH-1:0] res,
                                            input logic c);
    return {v, res[WIDTH-1], (res == '0), c};
  endfunction

  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign c_eff      = use_cf ? flags_q[0] : cin;

  assign alu_out    = out_q;
  assign alu_out_hi = hi_q;
  assign flags      = flags_q;
  assign cout       = flags_q[0];
  assign out_valid  = vld_p0_q;

  // Shared adder for ops 0-3 and CMP: a + b_eff + c_add.
  always_comb begin
    b_eff = '0;
    c_add = c_eff;
    case (alu_sel)
      OP_ADD:  b_eff = b;
      OP_SUB:  b_eff = ~b;
      OP_DEC:  b_eff = '1;
      OP_CMP:  begin b_eff = ~b; c_add = 1'b1; end
      default: b_eff = '0;
    endcase
  end

  assign sum_w = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_add};
  // Signed overflow: operands agree in sign but the result does not.
  assign add_v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);

  // One shift-and-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    out_d    = out_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    vld_p0_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          vld_p0_d = 1'b1;
          case (alu_sel)
            OP_TRA, OP_ADD, OP_SUB, OP_DEC: begin
              out_d   = sum_w[WIDTH-1:0];
              hi_d    = '0;
              flags_d = pack_flags(add_v, sum_w[WIDTH-1:0], sum_w[WIDTH]);
            end
            OP_CMP: begin
              flags_d = pack_flags(add_v, sum_w[WIDTH-1:0], sum_w[WIDTH]);
            end
            OP_OR, OP_XOR, OP_AND, OP_NOT: begin
              case (alu_sel)
                OP_OR:   out_d = a | b;
                OP_XOR:  out_d = a ^ b;
                OP_AND:  out_d = a & b;
                default: out_d = ~a;
              endcase
              hi_d    = '0;
              flags_d = pack_flags(1'b0, out_d, 1'b0);
            end
            OP_SHL, OP_ROLC: begin
              out_d   = {a[WIDTH-2:0], (alu_sel == OP_ROLC) ? c_eff : 1'b0};
              hi_d    = '0;
              flags_d = pack_flags(1'b0, out_d, a[WIDTH-1]);
            end
            OP_SHR, OP_ASR: begin
              out_d   = {(alu_sel == OP_ASR) ? a[WIDTH-1] : 1'b0, a[WIDTH-1:1]};
              hi_d    = '0;
              flags_d = pack_flags(1'b0, out_d, a[0]);
            end
            OP_MUL: begin
              vld_p0_d = 1'b0;
              mcand_d  = {{WIDTH{1'b0}}, a};
              mplier_d = b;
              prod_d   = '0;
              cnt_d    = CW'(WIDTH);
              state_d  = BUSY;
            end
            default: ;  // reserved opcodes: strobe only
          endcase
        end
      end
      BUSY: begin
        prod_d   = prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d    = prod_nxt[WIDTH-1:0];
          hi_d     = prod_nxt[2*WIDTH-1:WIDTH];
          flags_d  = {1'b0, prod_nxt[2*WIDTH-1], (prod_nxt == '0),
                      (prod_nxt[2*WIDTH-1:WIDTH] != '0)};
          vld_p0_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result / flag register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      out_q    <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      vld_p0_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      out_q    <= out_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      vld_p0_q <= vld_p0_d;
    end
  end

endmodule

// File: tb/tb_reg_alu_n.sv
module tb_reg_alu_n;

  localparam int W   = 8;
  localparam int MOD = 256;

  logic clk, rst;

  // 8-bit instance
  logic       in_valid, in_ready, cin, use_cf, out_valid, cout;
  logic [3:0] alu_sel, flags;
  logic [7:0] a_i, b_i, alu_out, alu_out_hi;

  // 4-bit legacy instance
  logic       v4_in_valid, v4_in_ready, v4_cin, v4_use_cf, v4_out_valid, v4_cout;
  logic [3:0] v4_sel, v4_flags, v4_a, v4_b, v4_out, v4_hi;

  int n_chk  = 0;
  int n_fail = 0;

  int       m_out, m_hi;
  bit [3:0] m_flags;

  reg_alu_n #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .a(a_i), .b(b_i), .cin(cin), .use_cf(use_cf),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi), .cout(cout), .flags(flags),
    .out_valid(out_valid)
  );

  reg_alu_n #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .alu_sel(v4_sel), .a(v4_a), .b(v4_b), .cin(v4_cin), .use_cf(v4_use_cf),
    .alu_out(v4_out), .alu_out_hi(v4_hi), .cout(v4_cout), .flags(v4_flags),
    .out_valid(v4_out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the opcode rules.
  task automatic model_op(input int op, input int a, input int b, input bit c);
    int bp, cc, s, r, sa, sb, ss;
    longint p;
    bit cf, vf;
    case (op)
      0, 1, 2, 3, 13: begin
        case (op)
          0:       bp = 0;
          1:       bp = b;
          3:       bp = MOD - 1;
          default: bp = MOD - 1 - b;
        endcase
        cc = (op == 13) ? 1 : int'(c);
        s  = a + bp + cc;
        r  = s % MOD;
        cf = (s >= MOD);
        sa = (a  >= MOD/2) ? a  - MOD : a;
        sb = (bp >= MOD/2) ? bp - MOD : bp;
        ss = sa + sb + cc;
        vf = (ss >= MOD/2) || (ss < -MOD/2);
        if (op != 13) begin m_out = r; m_hi = 0; end
        m_flags = {vf, r >= MOD/2, r == 0, cf};
      end
      4, 5, 6, 7, 8, 9, 10, 11: begin
        cf = 1'b0;
        case (op)
          4:  r = a | b;
          5:  r = a ^ b;
          6:  r = a & b;
          7:  r = MOD - 1 - a;
          8:  begin r = (a * 2) % MOD;         cf = (a >= MOD/2); end
          9:  begin r = a / 2;                 cf = (a % 2) == 1; end
          10: begin r = a / 2 + ((a >= MOD/2) ? MOD/2 : 0); cf = (a % 2) == 1; end
          default: begin r = (a * 2) % MOD + int'(c); cf = (a >= MOD/2); end
        endcase
        m_out = r; m_hi = 0;
        m_flags = {1'b0, r >= MOD/2, r == 0, cf};
      end
      12: begin
        p = longint'(a) * longint'(b);
        m_hi  = int'(p / MOD);
        m_out = int'(p % MOD);
        m_flags = {1'b0, m_hi >= MOD/2, p == 0, m_hi != 0};
      end
      default: ;
    endcase
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_out"},   32'(alu_out),    32'(m_out));
    chk({tag, "_hi"},    32'(alu_out_hi), 32'(m_hi));
    chk({tag, "_flags"}, 32'(flags),      32'(m_flags));
    chk({tag, "_cout"},  32'(cout),       32'(m_flags[0]));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_ovld",  32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready),  32'd1);
    chk_outs("idle");
  endtask

  // Drives one op; leaves in_valid high for non-MUL so a following call
  // issues back-to-back.
  task automatic do_op(input int op, input int a, input int b, input bit ci, input bit ucf);
    bit c;
    chk("pre_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_sel = 4'(op); a_i = 8'(a); b_i = 8'(b); cin = ci; use_cf = ucf;
    c = ucf ? m_flags[0] : ci;
    @(posedge clk); #1;
    model_op(op, a, b, c);
    if (op == 12) begin
      alu_sel = 4'd1;  // junk request held during BUSY must be ignored
      chk("mul_busy_ready", 32'(in_ready),  32'd0);
      chk("mul_busy_ovld",  32'(out_valid), 32'd0);
      for (int k = 1; k < W; k++) begin
        @(posedge clk); #1;
        chk("mul_busy_ready", 32'(in_ready),  32'd0);
        chk("mul_busy_ovld",  32'(out_valid), 32'd0);
      end
      @(posedge clk); #1;
      chk("mul_done_ready", 32'(in_ready),  32'd1);
      chk("mul_done_ovld",  32'(out_valid), 32'd1);
      chk_outs("mul");
      in_valid = 1'b0;
    end else begin
      chk("op_ovld", 32'(out_valid), 32'd1);
      chk_outs("op");
    end
  endtask

  task automatic op4(input int op, input int a, input int b, input bit ci,
                     input int exp_out, input bit exp_c);
    v4_in_valid = 1'b1; v4_sel = 4'(op); v4_a = 4'(a); v4_b = 4'(b); v4_cin = ci;
    @(posedge clk); #1;
    v4_in_valid = 1'b0;
    chk("w4_ovld", 32'(v4_out_valid), 32'd1);
    chk("w4_out",  32'(v4_out),       32'(exp_out));
    chk("w4_cout", 32'(v4_cout),      32'(exp_c));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; alu_sel = '0; a_i = '0; b_i = '0; cin = 1'b0; use_cf = 1'b0;
    v4_in_valid = 1'b0; v4_sel = '0; v4_a = '0; v4_b = '0; v4_cin = 1'b0; v4_use_cf = 1'b0;
    m_out = 0; m_hi = 0; m_flags = '0;

    @(posedge clk); #1;
    chk("rst_ready", 32'(in_ready),  32'd0);
    chk("rst_ovld",  32'(out_valid), 32'd0);
    chk_outs("rst");
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(in_ready), 32'd1);

    // 4-bit legacy results
    op4(2, 4'b1010, 4'b0011, 1'b1, 4'b0111, 1'b1);
    op4(7, 4'b1010, 4'b0000, 1'b0, 4'b0101, 1'b0);
    op4(3, 4'b0111, 4'b0000, 1'b1, 4'b0111, 1'b1);

    // Signed overflow
    do_op(1, 8'h7F, 8'h01, 1'b0, 1'b0);
    chk("ovf_out",   32'(alu_out), 32'h80);
    chk("ovf_flags", 32'(flags),   32'hC);
    idle();

    // Carry chain, back to back
    do_op(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    chk("cc1_out",   32'(alu_out), 32'h00);
    chk("cc1_flags", 32'(flags),   32'h3);
    do_op(1, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("cc2_out",   32'(alu_out), 32'h01);
    chk("cc2_flags", 32'(flags),   32'h0);
    idle();

    // Multiply with in_valid held high
    do_op(12, 8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("mulff_hi",    32'(alu_out_hi), 32'hFE);
    chk("mulff_lo",    32'(alu_out),    32'h01);
    chk("mulff_flags", 32'(flags),      32'h5);
    idle();
    idle();

    // CMP leaves result untouched; ROLC rotates in stored C
    do_op(4, 8'h33, 8'h00, 1'b0, 1'b0);
    do_op(13, 8'h05, 8'h05, 1'b0, 1'b0);
    chk("cmp_out",   32'(alu_out), 32'h33);
    chk("cmp_flags", 32'(flags),   32'h3);
    do_op(11, 8'h80, 8'h00, 1'b0, 1'b1);
    chk("rolc_out",   32'(alu_out), 32'h01);
    chk("rolc_flags", 32'(flags),   32'h1);
    do_op(14, 8'hAA, 8'h55, 1'b1, 1'b0);
    idle();

    // Randomised ops with random gaps
    for (int i = 0; i < 300; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    // Reset in the middle of a multiply
    in_valid = 1'b1; alu_sel = 4'd12; a_i = 8'hC3; b_i = 8'h5A; use_cf = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    m_out = 0; m_hi = 0; m_flags = '0;
    chk("abort_ready", 32'(in_ready),  32'd0);
    chk("abort_ovld",  32'(out_valid), 32'd0);
    chk_outs("abort");
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", 32'(in_ready), 32'd1);
    repeat (W + 2) idle();
    do_op(1, 8'h12, 8'h34, 1'b1, 1'b0);
    chk("post_abort_out", 32'(alu_out), 32'h47);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
